// File: rtl/led_rate_sequencer.sv
// ============================================================================
// led_rate_sequencer: steps led_blinker through a programmable rate/dwell table
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_rate_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [1:0]    i_wr_rate,
  input  logic [DW-1:0] i_wr_dwell,
  input  logic [AW:0]   i_num_steps,
  input  logic          i_loop,
  input  logic          i_start,
  input  logic          i_stop,
  output logic          o_enable,
  output logic          o_switch_1,
  output logic          o_switch_2,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_step
);

  localparam logic [0:0]  IDLE      = 1'b0;
  localparam logic [0:0]  RUN       = 1'b1;
  localparam logic [AW:0] MAX_STEPS = (AW+1)'(DEPTH);

  logic [1:0]    rate_mem  [DEPTH];
  logic [DW-1:0] dwell_mem [DEPTH];

  logic [0:0]    state;
  logic [AW-1:0] step;
  logic [AW-1:0] last_step;
  logic [DW-1:0] count;
  logic [1:0]    cur_rate;
  logic          done;

  logic [AW:0]   n_eff;
  logic [AW:0]   n_minus_1;
  logic          advance;
  logic [AW-1:0] load_idx;
  logic [1:0]    load_rate;
  logic [DW-1:0] load_dwell;
  logic [DW-1:0] load_count;

  // Clamp the requested step count into 1..DEPTH, then keep the last index.
  always_comb begin
    if (i_num_steps == '0)
      n_eff = (AW+1)'(1);
    else if (i_num_steps > MAX_STEPS)
      n_eff = MAX_STEPS;
    else
      n_eff = i_num_steps;
    n_minus_1 = n_eff - (AW+1)'(1);
  end

  // Entry to load next: the following step mid-sequence, otherwise step 0.
  assign advance    = (state == RUN) && (count == '0) && (step != last_step);
  assign load_idx   = advance ? step + AW'(1) : '0;
  assign load_rate  = rate_mem[load_idx];
  assign load_dwell = dwell_mem[load_idx];
  assign load_count = (load_dwell == '0) ? '0 : load_dwell - DW'(1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        rate_mem[k]  <= '0;
        dwell_mem[k] <= '0;
      end
    end else if (i_wr_en) begin
      rate_mem[i_wr_addr]  <= i_wr_rate;
      dwell_mem[i_wr_addr] <= i_wr_dwell;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      step      <= '0;
      last_step <= '0;
      count     <= '0;
      cur_rate  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            state     <= RUN;
            step      <= '0;
            last_step <= n_minus_1[AW-1:0];
            count     <= load_count;
            cur_rate  <= load_rate;
          end
        end
        default: begin
          if (i_stop) begin
            state    <= IDLE;
            step     <= '0;
            cur_rate <= '0;
          end else if (count != '0) begin
            count <= count - DW'(1);
          end else if (advance) begin
            step     <= load_idx;
            count    <= load_count;
            cur_rate <= load_rate;
          end else if (i_loop) begin
            step      <= '0;
            last_step <= n_minus_1[AW-1:0];
            count     <= load_count;
            cur_rate  <= load_rate;
          end else begin
            state    <= IDLE;
            step     <= '0;
            cur_rate <= '0;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_enable   = (state == RUN);
  assign o_busy     = (state == RUN);
  assign o_switch_1 = (state == RUN) & cur_rate[1];
  assign o_switch_2 = (state == RUN) & cur_rate[0];
  assign o_done     = done;
  assign o_step     = step;

endmodule

`default_nettype wire

// File: tb/tb_led_rate_sequencer.sv
// ============================================================================
// tb_led_rate_sequencer: table-driven and directed checks for led_rate_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_rate_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_rate;
  logic [DW-1:0] wr_dwell;
  logic [AW:0]   num_steps;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic          enable, sw1, sw2, busy, done;
  logic [AW-1:0] step;

  int checks = 0;
  int errors = 0;

  led_rate_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_rate   (wr_rate),
    .i_wr_dwell  (wr_dwell),
    .i_num_steps (num_steps),
    .i_loop      (loop_en),
    .i_start     (start),
    .i_stop      (stop),
    .o_enable    (enable),
    .o_switch_1  (sw1),
    .o_switch_2  (sw2),
    .o_busy      (busy),
    .o_done      (done),
    .o_step      (step)
  );

  always #5 clk = ~clk;

  // Packed output view: {enable, switch_1, switch_2, busy, done, step}
  function automatic logic [6:0] pack(input logic en, input logic [1:0] sw,
                                      input logic bz, input logic dn,
                                      input logic [1:0] st);
    return {en, sw, bz, dn, st};
  endfunction

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {enable, sw1, sw2, busy, done, step};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en/sw/busy/done/step=%b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [1:0] r, input int d);
    wr_en    = 1'b1;
    wr_addr  = AW'(a);
    wr_rate  = r;
    wr_dwell = DW'(d);
    tick();
    wr_en    = 1'b0;
  endtask

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [1:0]    rate;
    logic [DW-1:0] dwell;
    logic          start;
    logic          stop;
    logic [6:0]    exp;
  } vec_t;

  vec_t vecs[17];
  logic [6:0] idle_o;

  initial begin
    idle_o = pack(1'b0, 2'b00, 1'b0, 1'b0, 2'd0);
    vecs[0]  = '{1'b1, 2'd0, 2'b00, 16'd3, 1'b0, 1'b0, idle_o};
    vecs[1]  = '{1'b1, 2'd1, 2'b01, 16'd2, 1'b0, 1'b0, idle_o};
    vecs[2]  = '{1'b1, 2'd2, 2'b10, 16'd1, 1'b0, 1'b0, idle_o};
    vecs[3]  = '{1'b1, 2'd3, 2'b11, 16'd4, 1'b0, 1'b0, idle_o};
    vecs[4]  = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b1, 1'b1, idle_o};
    vecs[5]  = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b1, 1'b0, pack(1, 2'b00, 1, 0, 2'd0)};
    vecs[6]  = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b00, 1, 0, 2'd0)};
    vecs[7]  = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b1, 1'b0, pack(1, 2'b00, 1, 0, 2'd0)};
    vecs[8]  = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b01, 1, 0, 2'd1)};
    vecs[9]  = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b01, 1, 0, 2'd1)};
    vecs[10] = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b10, 1, 0, 2'd2)};
    vecs[11] = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b11, 1, 0, 2'd3)};
    vecs[12] = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b11, 1, 0, 2'd3)};
    vecs[13] = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b11, 1, 0, 2'd3)};
    vecs[14] = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(1, 2'b11, 1, 0, 2'd3)};
    vecs[15] = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, pack(0, 2'b00, 0, 1, 2'd0)};
    vecs[16] = '{1'b0, 2'd0, 2'b00, 16'd0, 1'b0, 1'b0, idle_o};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_rate = '0; wr_dwell = '0;
    num_steps = 3'd4; loop_en = 1'b0; start = 1'b0; stop = 1'b0;

    // Reset held: outputs stay idle across several edges
    #2 chk("reset_t0", idle_o);
    tick(); chk("reset_hold1", idle_o);
    tick(); chk("reset_hold2", idle_o);
    #2 rst = 1'b0;
    tick(); chk("idle_after_reset", idle_o);

    // Single pass (row 7 also pulses start mid-run; it must be ignored)
    for (int i = 0; i < 17; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].addr;
      wr_rate = vecs[i].rate; wr_dwell = vecs[i].dwell;
      start = vecs[i].start; stop = vecs[i].stop;
      tick();
      chk($sformatf("single_pass_row%0d", i), vecs[i].exp);
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;

    // Loop with zero dwell on entry 1: period 00,00,00,01
    write_entry(1, 2'b01, 0);
    num_steps = 3'd2; loop_en = 1'b1; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      start = 1'b0;
      if ((k % 4) < 3) chk($sformatf("loop_c%0d", k), pack(1, 2'b00, 1, 0, 2'd0));
      else             chk($sformatf("loop_c%0d", k), pack(1, 2'b01, 1, 0, 2'd1));
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("loop_stop", idle_o);

    // Stop in the second cycle of step 1
    write_entry(1, 2'b01, 2);
    num_steps = 3'd4; loop_en = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("stop_s1_c1", pack(1, 2'b01, 1, 0, 2'd1));
    tick();
    chk("stop_s1_c2", pack(1, 2'b01, 1, 0, 2'd1));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_idle", idle_o);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_step0", pack(1, 2'b00, 1, 0, 2'd0));
    stop = 1'b1; tick(); stop = 1'b0;

    // Rewrite entry 0 while it is running; takes effect on the wrap
    num_steps = 3'd2; loop_en = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    write_entry(0, 2'b11, 3);
    chk("wr_run_old_rate", pack(1, 2'b00, 1, 0, 2'd0));
    tick(); chk("wr_run_old_rate2", pack(1, 2'b00, 1, 0, 2'd0));
    tick(); chk("wr_run_step1", pack(1, 2'b01, 1, 0, 2'd1));
    tick(); tick(); chk("wr_run_wrap_new", pack(1, 2'b11, 1, 0, 2'd0));
    stop = 1'b1; tick(); stop = 1'b0;

    // Async reset while step 2 is active
    num_steps = 3'd4; loop_en = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_reset_step2", pack(1, 2'b10, 1, 0, 2'd2));
    #2 rst = 1'b1;
    #1 chk("async_reset_clear", idle_o);
    #1 rst = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      start = 1'b0;
      chk($sformatf("post_reset_step%0d", k), pack(1, 2'b00, 1, 0, 2'(k)));
    end
    tick(); chk("post_reset_done", pack(0, 2'b00, 0, 1, 2'd0));

    // Out-of-range step count clamps to DEPTH (all entries now 1 cycle)
    num_steps = 3'd7; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("clamp_last_step", pack(1, 2'b00, 1, 0, 2'd3));
    tick(); chk("clamp_done", pack(0, 2'b00, 0, 1, 2'd0));

    // Zero step count behaves as one step
    num_steps = 3'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("n0_step0", pack(1, 2'b00, 1, 0, 2'd0));
    tick(); chk("n0_done", pack(0, 2'b00, 0, 1, 2'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
